// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} pairs with synchronous clear and occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  fetch_entry_t wr_entry,
  input  logic         rd_en,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_wr;
  logic          do_rd;

  // Clear wins over everything; a write into a full queue is only taken alongside a read.
  assign do_rd = rd_en && !clear && (count_q != '0);
  assign do_wr = wr_en && !clear && ((count_q != CW'(DEPTH)) || do_rd);

  assign head  = mem[rd_ptr];
  assign count = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/instruction_fetch.sv
// In-order instruction fetch with credit-limited prefetch and redirect flush.
// Optional stall counter output is enabled by defining FETCH_PERF_EN.
//
//  state | meaning
//  IDLE  | one cycle after reset before the first request
//  FETCH | issuing requests while credits remain, queueing responses
//  FLUSH | dropping responses that were in flight at a redirect
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] START_PC = RESET_PC & ~XLEN'(3);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] resp_pc, resp_pc_next;
  logic [CW-1:0]   outstanding, outstanding_next;
  logic [CW-1:0]   discard, discard_next;
  logic [CW-1:0]   occupancy;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;
  logic            accept;
  logic            resp_live;
  logic            q_wr, q_rd, q_clear;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  // Request validity depends only on registered state, never on ready inputs.
  assign imem_req_valid = (state == FETCH) && ((occupancy + outstanding) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (outstanding != '0);

  assign inst_valid = (occupancy != '0);
  assign inst_data  = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  assign wr_entry.pc   = resp_pc;
  assign wr_entry.inst = imem_resp_data;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .clear    (q_clear),
    .wr_en    (q_wr),
    .wr_entry (wr_entry),
    .rd_en    (q_rd),
    .head     (head),
    .count    (occupancy)
  );

  // State, PC and credit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= START_PC;
      resp_pc     <= START_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      resp_pc     <= resp_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
    end
  end

  // Next-state, credit accounting and queue control; redirect overrides last.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    resp_pc_next     = resp_pc;
    outstanding_next = outstanding;
    discard_next     = discard;
    q_wr             = 1'b0;
    q_rd             = 1'b0;
    q_clear          = 1'b0;

    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (accept) fetch_pc_next = fetch_pc + PC_STEP;
        if (resp_live) begin
          q_wr         = 1'b1;
          resp_pc_next = resp_pc + PC_STEP;
        end
        outstanding_next = outstanding + CW'(accept) - CW'(resp_live);
        q_rd = inst_valid && inst_ready;
      end
      FLUSH: begin
        if (discard == '0) begin
          state_next = FETCH;
        end else if (imem_resp_valid) begin
          discard_next = discard - CW'(1);
          if (discard == CW'(1)) state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
      resp_pc_next  = redirect_target;
      q_clear       = 1'b1;
      q_wr          = 1'b0;
      q_rd          = 1'b0;
      // In FLUSH the pending discard count already covers everything in flight.
      if (state != FLUSH) begin
        discard_next     = outstanding + CW'(accept) - CW'(resp_live);
        outstanding_next = '0;
        state_next       = (discard_next != '0) ? FLUSH : FETCH;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of FETCH cycles with nothing to hand to decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
    end else if ((state == FETCH) && !inst_valid && (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run against a program-order reference (expected PC stream and a hashed memory image).
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int total = 0;
  int bad = 0;

  instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
  endtask

  // Leaves the DUT in its single IDLE cycle right after reset release.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    imem_req_ready = 1'b1;
    tick();
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid); end
    total++; if (imem_req_addr !== RESET_PC) begin bad++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%0h exp=0", inst_valid); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL reset_inst_data got=%h exp=0", inst_data); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
    reset = 1'b1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_cycle_req_valid got=%0h exp=0", imem_req_valid); end
    tick();
  endtask

  // Continues from test_reset: first FETCH cycle, ready held high, no responses.
  task automatic test_fetch_seq();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 32'(4 * i)) begin
        bad++; $display("FAIL seq_req_%0d got valid=%0h addr=%h exp valid=1 addr=%h", i, imem_req_valid, imem_req_addr, RESET_PC + 32'(4 * i));
      end
      tick();
    end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL seq_credit_stop got=%0h exp=0", imem_req_valid); end
    imem_req_ready = 1'b0;
  endtask

  // Continues with four requests outstanding.
  task automatic test_response_order();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00500093;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h00500093) begin
      bad++; $display("FAIL resp_first got valid=%0h pc=%h data=%h exp 1 0 00500093", inst_valid, inst_pc, inst_data);
    end
    imem_resp_data = 32'h00100113;
    inst_ready     = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h00100113) begin
      bad++; $display("FAIL resp_second got valid=%0h pc=%h data=%h exp 1 4 00100113", inst_valid, inst_pc, inst_data);
    end
    tick();
    inst_ready = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL resp_drained got=%0h exp=0", inst_valid); end
  endtask

  task automatic test_full_credit();
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    repeat (4) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_no_req_%0d got=%0h exp=0", i, imem_req_valid); end
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(32'(4 * i));
      tick();
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      bad++; $display("FAIL full_hold got req=%0h valid=%0h pc=%h exp 0 1 0", imem_req_valid, inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_no_comb_path got=%0h exp=0", imem_req_valid); end
    tick();
    inst_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10 || inst_pc !== 32'h4) begin
      bad++; $display("FAIL full_one_credit got req=%0h addr=%h pc=%h exp 1 10 4", imem_req_valid, imem_req_addr, inst_pc);
    end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_exactly_one got=%0h exp=0", imem_req_valid); end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_still_none got=%0h exp=0", imem_req_valid); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_flush();
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_entry got req=%0h valid=%0h exp 0 0", imem_req_valid, inst_valid);
    end
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD0001;
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_one_left got=%0h exp=0", imem_req_valid); end
    imem_resp_data = 32'hDEAD0002;
    tick();
    imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_exit got req=%0h addr=%h valid=%0h exp 1 40 0", imem_req_valid, imem_req_addr, inst_valid);
    end
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(32'h40);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== mem_word(32'h40)) begin
      bad++; $display("FAIL flush_first_inst got valid=%0h pc=%h data=%h exp 1 40 %h", inst_valid, inst_pc, inst_data, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD00000;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h80;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle_flush got req=%0h valid=%0h exp 0 0", imem_req_valid, inst_valid);
    end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_waits got=%0h exp=0", imem_req_valid); end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD00004;
    tick();
    imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle_one_discard got req=%0h addr=%h valid=%0h exp 1 80 0", imem_req_valid, imem_req_addr, inst_valid);
    end
    imem_req_ready = 1'b0;
  endtask

  // Redirect issued in the IDLE cycle, to the top of the address space.
  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFF;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC) begin
      bad++; $display("FAIL wrap_first got req=%0h addr=%h exp 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_second got req=%0h addr=%h exp 1 0", imem_req_valid, imem_req_addr);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(32'hFFFFFFFC);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFFFFFC) begin
      bad++; $display("FAIL wrap_inst_pc got valid=%0h pc=%h exp 1 fffffffc", inst_valid, inst_pc);
    end
  endtask

  // Random bus latency, ready and redirects; decode must see the program-order stream.
  task automatic test_random();
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_pc;
    logic [31:0] target;
    int          consumed;
    bit          after_redirect;
    bit          redir;
    bit          rdy;
    do_reset();
    exp_pc = RESET_PC;
    consumed = 0;
    after_redirect = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (after_redirect) begin
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rand_post_redirect cycle=%0d got=%0h exp=0", c, inst_valid); end
      end
      after_redirect = 1'b0;
      if (inst_valid === 1'b1) begin
        total++; if (inst_data !== mem_word(inst_pc)) begin
          bad++; $display("FAIL rand_data cycle=%0d pc=%h got=%h exp=%h", c, inst_pc, inst_data, mem_word(inst_pc));
        end
      end
      redir = ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      inst_ready = rdy;
      if (redir) begin
        target         = $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        exp_pc         = target & ~32'h3;
        after_redirect = 1'b1;
      end else begin
        redirect_valid = 1'b0;
        if (inst_valid === 1'b1 && rdy) begin
          total++; if (inst_pc !== exp_pc) begin
            bad++; $display("FAIL rand_order cycle=%0d got=%h exp=%h", c, inst_pc, exp_pc);
          end
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
      if (pend_addr.size() > 0 && pend_due[0] <= c) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (imem_req_valid === 1'b1 && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(c + int'($urandom_range(1, 5)));
        total++; if (pend_addr.size() > DEPTH) begin
          bad++; $display("FAIL rand_credit cycle=%0d inflight=%0d max=%0d", c, pend_addr.size(), DEPTH);
        end
      end
      tick();
    end
    clear_inputs();
    total++; if (consumed < 200) begin bad++; $display("FAIL rand_progress got=%0d exp>=200", consumed); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    total++; if (perf_stall_cycles !== 32'd0) begin bad++; $display("FAIL perf_idle got=%0d exp=0", perf_stall_cycles); end
    repeat (4) tick();
    total++; if (perf_stall_cycles !== 32'd3) begin bad++; $display("FAIL perf_three got=%0d exp=3", perf_stall_cycles); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++; if (perf_stall_cycles !== 32'd5) begin bad++; $display("FAIL perf_flush_entry got=%0d exp=5", perf_stall_cycles); end
    repeat (3) tick();
    total++; if (perf_stall_cycles !== 32'd5) begin bad++; $display("FAIL perf_flush_hold got=%0d exp=5", perf_stall_cycles); end
    imem_resp_valid = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    tick();
    total++; if (perf_stall_cycles !== 32'd6) begin bad++; $display("FAIL perf_resume got=%0d exp=6", perf_stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_seq();
    test_response_order();
    test_full_credit();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of the single-cycle RV32I datapath. It issues in-order word requests to an external instruction memory bus with variable latency, buffers returned words with their PCs in a small prefetch queue, and presents them to decode over a valid/ready handshake. A redirect input from the branch/jump logic (JAL, JALR, BEQ/BNE) flushes the queue and discards any responses still in flight.

## Interface
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, 2..16.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  bus accepts request.
- imem_resp_valid  in  1  response valid; in order; no backpressure.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_ready  in  1  decode consumes head.
- redirect_valid  in  1  control-flow change.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.

## Operation
- FSM: IDLE, FETCH, FLUSH. Reset → IDLE; IDLE → FETCH unconditionally next cycle (IDLE + redirect: load PC, → FETCH).
- FETCH: imem_req_valid = (occupancy + outstanding < DEPTH); driven only from registers, with no combinational path from inst_ready or imem_req_ready.
- Acceptance (valid && ready): outstanding += 1; fetch PC += 4 (mod 2^32, so 0xFFFFFFFC wraps to 0).
- Response: written to queue tail with resp_pc; resp_pc += 4; outstanding -= 1. A response arriving with outstanding == 0 is ignored.
- Dequeue on inst_valid && inst_ready.
- Redirect (any state; highest priority):
  - queue cleared;
  - fetch PC and resp_pc set to {redirect_pc[31:2], 2'b00};
  - in-flight count, including a request accepted the same cycle and minus a response arriving the same cycle (which is discarded), moves to discard.
  - If discard > 0, → FLUSH; else → FETCH.
  - A dequeue handshake in the redirect cycle is ignored.
- FLUSH: imem_req_valid = 0; each response is dropped and decrements discard; → FETCH on the response that brings discard to 0. Redirect in FLUSH updates PCs only.

## Timing
- Reset values:
  - imem_req_valid 0, imem_req_addr RESET_PC;
  - inst_valid 0, inst_data 0, inst_pc 0;
  - state IDLE; counters 0.
- First request: imem_req_valid rises in the second cycle after reset deasserts (one cycle in IDLE).
- Response at edge N → inst_valid high in cycle N+1 (one-cycle queue latency). A full queue still accepts responses, because credits guarantee space.
- A dequeue at edge N frees a credit; a new request can assert in cycle N+1.
- Redirect at edge N: inst_valid = 0 in cycle N+1; if no discard is pending, imem_req_valid = 1 with the new address in cycle N+1.
- Reset mid-operation: all state cleared immediately; late bus responses after reset are the bus's responsibility (outstanding == 0, so they are ignored).

## Configuration
- FETCH_PERF_EN defined: adds output perf_stall_cycles (32 bit, reset 0).
  - Increments in every FETCH cycle where inst_valid == 0.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, FETCH, FLUSH);
  - the 32-bit word/address width constant;
  - the PC increment constant 4.
- Sub-module fetch_queue: synchronous FIFO of {pc, instruction}, DEPTH entries, with synchronous clear and occupancy output.
- Counters are sized $clog2(DEPTH)+1.

## Test plan
- Reset release, imem_req_ready=1, no responses → addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles, then imem_req_valid=0 (DEPTH=4).
- Responses 0x00500093, 0x00100113 → inst_valid next cycle with inst_pc 0x0 then 0x4, in order.
- inst_ready=0, four responses → queue full, no requests. One dequeue → exactly one request in the following cycle.
- Two requests in flight, redirect to 0x40 → FLUSH; both responses dropped; next request 0x40; first instruction shown has pc 0x40.
- Redirect in the same cycle as an accepted request and a response → 1 discard (one added, one dropped).
- redirect_pc 0xFFFFFFFF → requests 0xFFFFFFFC, then 0x0.
- FETCH_PERF_EN: queue empty for 3 FETCH cycles → perf_stall_cycles == 3; no increment in IDLE or FLUSH.
